// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (ifetch = req0, LSU = req1) in front of a single-ported memory.
// Optional MEM_ARB_FIXED_PRIO_EN: LSU wins every tie instead of round-robin.
module mem_port_arbiter #(
    parameter int WIDTH          = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [WIDTH-1:0]      i_req0_wdata,
    input  logic                  i_req0_we,
    input  logic                  i_req1_valid,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [WIDTH-1:0]      i_req1_wdata,
    input  logic                  i_req1_we,
    output logic                  o_req0_ready,
    output logic                  o_req1_ready,
    output logic                  o_rsp0_valid,
    output logic                  o_rsp1_valid,
    output logic                  o_rsp_err,
    output logic [WIDTH-1:0]      o_rsp_rdata,
    output logic                  o_sel,
    output logic                  o_mem_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0]      o_mem_wdata,
    output logic                  o_mem_we,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rsp_valid,
    input  logic [WIDTH-1:0]      i_mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          next_sel;
    logic          win_valid;
    logic          accept;
    logic          rsp_hit;
    logic          tmo_hit;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign next_sel = i_req1_valid;
`else
    logic last_grant;
    // Single valid wins outright; on a tie, whoever did not win last time.
    assign next_sel = (i_req0_valid && i_req1_valid) ? ~last_grant : i_req1_valid;
`endif

    assign win_valid = o_sel ? i_req1_valid : i_req0_valid;
    assign accept    = (state == ISSUE) && i_mem_ready;
    assign rsp_hit   = (state == WAIT) && i_mem_rsp_valid;
    // A response arriving on the final cycle beats the timeout.
    assign tmo_hit   = (state == WAIT) && !i_mem_rsp_valid && (cnt >= CW'(TIMEOUT_CYCLES - 1));

    assign o_mem_valid  = (state == ISSUE);
    assign o_req0_ready = accept && !o_sel;
    assign o_req1_ready = accept &&  o_sel;

    assign o_mem_addr  = o_sel ? i_req1_addr  : i_req0_addr;
    assign o_mem_wdata = o_sel ? i_req1_wdata : i_req0_wdata;
    assign o_mem_we    = o_sel ? i_req1_we    : i_req0_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_sel        <= 1'b0;
            cnt          <= '0;
            o_rsp0_valid <= 1'b0;
            o_rsp1_valid <= 1'b0;
            o_rsp_err    <= 1'b0;
            o_rsp_rdata  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            o_rsp0_valid <= 1'b0;
            o_rsp1_valid <= 1'b0;
            o_rsp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req0_valid || i_req1_valid) begin
                        o_sel <= next_sel;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_grant <= next_sel;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_mem_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else if (!win_valid) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (rsp_hit) begin
                        o_rsp_rdata  <= i_mem_rdata;
                        o_rsp0_valid <= !o_sel;
                        o_rsp1_valid <= o_sel;
                        state        <= IDLE;
                    end else if (tmo_hit) begin
                        o_rsp_rdata  <= '0;
                        o_rsp_err    <= 1'b1;
                        o_rsp0_valid <= !o_sel;
                        o_rsp1_valid <= o_sel;
                        state        <= IDLE;
                    end else if (cnt != CW'(TIMEOUT_CYCLES)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with TIMEOUT_CYCLES=4.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_we, req1_we;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sel, mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata), .i_req0_we(req0_we),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata), .i_req1_we(req1_we),
        .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
        .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
        .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata), .o_sel(sel),
        .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .i_mem_ready(mem_ready), .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rdata(mem_rdata)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0;
        req0_addr = 0; req1_addr = 0; req0_wdata = 0; req1_wdata = 0;
        mem_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_n = 0;
        cyc();
        cyc();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset;
        logic [6:0] ctl;
        clear_inputs();
        rst_n = 0;
        req0_valid = 1; req1_valid = 1;
        repeat (3) cyc();
        ctl = {sel, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, mem_valid};
        n_checks++;
        if (ctl !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000000", ctl);
        end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
        end
        rst_n = 1;
        cyc();
        n_checks++;
        if (sel !== 1'b0 || mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_grant: sel=%b mem_valid=%b want sel=0 mem_valid=1", sel, mem_valid);
        end
        mem_ready = 1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_first_ready: r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_single_read;
        apply_reset();
        req1_valid = 1; req1_addr = 32'h40; req1_we = 0;
        cyc();
        n_checks++;
        if (sel !== 1'b1 || mem_valid !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL read_issue: sel=%b mem_valid=%b r1=%b want 1 1 0", sel, mem_valid, req1_ready);
        end
        mem_ready = 1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL read_accept: r1=%b r0=%b addr=%h we=%b want 1 0 40 0", req1_ready, req0_ready, mem_addr, mem_we);
        end
        cyc();
        req1_valid = 0; mem_ready = 0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL read_wait: mem_valid=%b r1=%b want 0 0", mem_valid, req1_ready);
        end
        cyc();
        cyc();
        mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF;
        n_checks++;
        if (rsp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_early_rsp: rsp1=%b want 0", rsp1_valid);
        end
        cyc();
        mem_rsp_valid = 0; mem_rdata = 0;
        n_checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_rsp: rsp1=%b rsp0=%b err=%b rdata=%h want 1 0 0 deadbeef", rsp1_valid, rsp0_valid, rsp_err, rsp_rdata);
        end
        cyc();
        n_checks++;
        if (rsp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_rsp_pulse: rsp1=%b want 0", rsp1_valid);
        end
    endtask

    task automatic test_grant_order;
        int got[4];
        int ng;
        int want;
        apply_reset();
        req0_valid = 1; req1_valid = 1; mem_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            cyc();
            if (req0_ready === 1'b1) begin got[ng] = 0; ng++; end
            else if (req1_ready === 1'b1) begin got[ng] = 1; ng++; end
        end
        n_checks++;
        if (ng != 4) begin
            n_fail++; $display("FAIL grant_count: got %0d grants want 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            want = 1;
`else
            want = i % 2;
`endif
            n_checks++;
            if (got[i] != want) begin
                n_fail++; $display("FAIL grant_%0d: got req%0d want req%0d", i, got[i], want);
            end
        end
        clear_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_timeout_tie;
        apply_reset();
        req1_valid = 1; mem_ready = 1;
        cyc();
        cyc();
        req1_valid = 0; mem_ready = 0;
        cyc();
        cyc();
        cyc();
        mem_rsp_valid = 1; mem_rdata = 32'hCAFEF00D;
        cyc();
        mem_rsp_valid = 0; mem_rdata = 0;
        n_checks++;
        if (rsp1_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL tie_rsp: rsp1=%b err=%b rdata=%h want 1 0 cafef00d", rsp1_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_timeout;
        req0_valid = 1; mem_ready = 1; mem_rdata = 32'h12345678;
        cyc();
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL tmo_accept: r0=%b want 1", req0_ready);
        end
        cyc();
        req0_valid = 0; mem_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_checks++;
            if (k < 4) begin
                if (rsp0_valid !== 1'b0) begin
                    n_fail++; $display("FAIL tmo_early_%0d: rsp0=%b want 0", k, rsp0_valid);
                end
            end else if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
                n_fail++; $display("FAIL tmo_rsp: rsp0=%b rsp1=%b err=%b rdata=%h want 1 0 1 0", rsp0_valid, rsp1_valid, rsp_err, rsp_rdata);
            end
        end
        mem_rsp_valid = 1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                n_fail++; $display("FAIL tmo_late_rsp_%0d: rsp0=%b rsp1=%b want 0 0", k, rsp0_valid, rsp1_valid);
            end
        end
        clear_inputs();
    endtask

    task automatic test_abort;
        apply_reset();
        req0_valid = 1;
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_issue: mem_valid=%b r0=%b want 1 0", mem_valid, req0_ready);
        end
        req0_valid = 0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_drop: r0=%b want 0", req0_ready);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if ({mem_valid, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
                n_fail++; $display("FAIL abort_idle_%0d: got %b want 00000", k, {mem_valid, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
            end
        end
    endtask

    task automatic test_reset_in_wait;
        apply_reset();
        req1_valid = 1; mem_ready = 1;
        cyc();
        cyc();
        req1_valid = 0; mem_ready = 0;
        n_checks++;
        if (sel !== 1'b1 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_pre: sel=%b mem_valid=%b want 1 0", sel, mem_valid);
        end
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if ({sel, mem_valid, rsp0_valid, rsp1_valid, rsp_err} !== 5'b0) begin
            n_fail++; $display("FAIL rstwait_clear: got %b want 00000", {sel, mem_valid, rsp0_valid, rsp1_valid, rsp_err});
        end
        cyc();
        rst_n = 1;
        mem_rsp_valid = 1; mem_rdata = 32'hA5A5A5A5;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
                n_fail++; $display("FAIL rstwait_rsp_%0d: rsp0=%b rsp1=%b rdata=%h want 0 0 0", k, rsp0_valid, rsp1_valid, rsp_rdata);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_single_read();
        test_grant_order();
        test_timeout_tie();
        test_timeout();
        test_abort();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
